// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle RV64 main control FSM.
package cpu_pkg;

  localparam int unsigned OP_W = 7;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_SB = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Full datapath control word driven by the FSM.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_sel;
    logic       illegal_instr;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Combinational map from FSM state and IR opcode to the datapath control word.
module multicycle_output_decode
  import cpu_pkg::*;
(
  input  logic [2:0]        state,
  input  logic [OP_W-1:0]   opcode,
  input  logic              zero,
  input  logic              mem_ready,
  input  logic              hold_active,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  // The PC-load gate on zero lives in the datapath; the FSM stays Moore on it.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    c         = '0;
    c.imm_sel = opcode[6:5];
    case (state_t'(state))
      FETCH: begin
        if (hold_active) begin
          c = '0;
        end else begin
          c.mem_read  = 1'b1;
          c.alu_src_b = SRCB_FOUR;
          c.alu_op    = ALU_ADD;
          c.ir_write  = mem_ready;
          c.pc_write  = mem_ready;
        end
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM;
        c.imm_sel   = IMM_SB;
        c.alu_op    = ALU_ADD;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        case (opcode)
          OP_R: begin
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALU_FUNCT;
          end
          OP_IMM: begin
            c.alu_src_b = SRCB_IMM;
            c.imm_sel   = IMM_I;
            c.alu_op    = ALU_FUNCT;
          end
          OP_LOAD: begin
            c.alu_src_b = SRCB_IMM;
            c.imm_sel   = IMM_I;
            c.alu_op    = ALU_ADD;
          end
          OP_STORE: begin
            c.alu_src_b = SRCB_IMM;
            c.imm_sel   = IMM_S;
            c.alu_op    = ALU_ADD;
          end
          OP_BRANCH: begin
            c.alu_src_b     = SRCB_RS2;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_src        = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        c.i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          c.mem_read = 1'b1;
        end else if (opcode == OP_STORE) begin
          c.mem_write = 1'b1;
        end
      end
      WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = (opcode == OP_LOAD);
      end
      TRAP: begin
        c               = '0;
        c.illegal_instr = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV64 datapath.
// Optional performance counters enabled by MULTICYCLE_PERF_COUNTERS_EN.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_sel,
  output logic             illegal_instr
`ifdef MULTICYCLE_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int unsigned HOLD_W = 2;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CTRL_W-1:0]   ctrl_raw;
  ctrl_t               ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      hold_q  <= HOLD_W'(RESET_PC_HOLD);
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      FETCH: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (mem_ready) begin
          state_d = DECODE;
        end
      end
      DECODE: state_d = is_valid_op(opcode) ? EXEC : TRAP;
      EXEC: begin
        case (opcode)
          OP_R, OP_IMM:      state_d = WB;
          OP_LOAD, OP_STORE: state_d = MEM;
          default:           state_d = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          state_d = (opcode == OP_LOAD) ? WB : FETCH;
        end
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  multicycle_output_decode u_decode (
    .state       (state_q),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .hold_active (hold_q != '0),
    .ctrl        (ctrl_raw)
  );

  // Asserting reset kills every request in the same cycle, before any edge.
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      ctrl = ctrl_t'(ctrl_raw);
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign ir_write      = ctrl.ir_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign imm_sel       = ctrl.imm_sel;
  assign illegal_instr = ctrl.illegal_instr;

`ifdef MULTICYCLE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // An instruction retires on the cycle its final state is left.
  always_comb begin
    retire    = (state_q == WB) ||
                ((state_q == MEM) && (opcode == OP_STORE) && mem_ready) ||
                ((state_q == EXEC) && (opcode == OP_BRANCH));
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (state_q != TRAP) begin
      cycle_d = cycle_q + CNT_W'(1);
    end
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule
